mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Sequences and arbitrates the single byte-wide RAM port between the instruction fetch unit and the load/store buffer.
- Accepts one request at a time, serialises it into 1/2/4 byte accesses, and assembles little-endian read data.
- Returns a one-cycle completion pulse to the winning requester.
- Owns the only path to RAM/UART. Provides the busy/finished/value/position handshake the load/store buffer consumes.

Parameters:
POS_W, 4, width of the load/store buffer entry index (log2 of buffer capacity)

Ports:
clk_in  input  1  system clock
rst_in  input  1  reset, asynchronous, active-low (0 = reset)
rdy_in  input  1  when low, pause: hold all state, force mem_wr=0
clear  input  1  pipeline flush from ROB (synchronous)
io_buffer_full  input  1  UART buffer full
if_req  input  1  fetch request (level, held until if_done)
if_addr  input  32  fetch address (word)
if_done  output  1  one-cycle fetch completion pulse
if_inst  output  32  fetched word, valid with if_done
lsb_req  input  1  LSB request, single-cycle strobe
lsb_pos  input  POS_W  LSB entry index
lsb_ls  input  1  0 = load, 1 = store
lsb_len  input  2  00 byte, 01 half, 10 word
lsb_addr  input  32  byte address
lsb_val  input  32  store data (low bytes used)
lsb_busy  output  1  LSB must not strobe lsb_req while high
lsb_finished  output  1  one-cycle completion pulse (load and store)
lsb_val_out  output  32  load data, zero-extended raw bytes
lsb_pos_out  output  POS_W  entry index echoed with lsb_finished
mem_din  input  8  RAM read byte
mem_dout  output  8  RAM write byte
mem_a  output  32  RAM byte address
mem_wr  output  1  1 = write

Behaviour:
- Reset (rst_in=0, async):
  - State IDLE; last_grant=IF.
  - if_done, lsb_finished, mem_wr and all data/address outputs = 0.
- States: IDLE, IF_RD, LS_RD, LS_WR. Byte counter k (0..n-1) with n=1/2/4 from len; IF always n=4.
- lsb_busy is combinational: (state!=IDLE) | (last_grant==LSB & if_req).
  - An lsb_req seen with lsb_busy=0 is always accepted; requests while busy are a protocol error, ignored.
- Arbitration in IDLE:
  - LSB wins unless last_grant==LSB and if_req=1.
  - last_grant updates on every grant (round robin).
  - Request latched in cycle T; access starts in cycle T+1.
- Read (IF_RD/LS_RD): mem_a = base+k in cycle T+1+k.
  - RAM returns the byte at T+2+k; byte k goes to bits [8k+7:8k].
  - Done pulse visible in cycle T+2+n (word: T+6), unused upper bits 0.
  - State is IDLE in that same cycle, so a new grant is possible there.
- Write (LS_WR): mem_wr=1, mem_a=base+k, mem_dout=lsb_val[8k+7:8k] in cycle T+1+k.
  - lsb_finished visible in cycle T+1+n.
- IO stall: an address with addr[17:16]==2'b11 is IO. While io_buffer_full=1 in a write cycle to an IO address: mem_wr=0, k holds; resume when low.
- Address arithmetic: 32-bit, wraps modulo 2^32.
- if_done/lsb_finished: exactly one cycle each; never both in the same cycle.
- clear:
  - IF_RD and LS_RD abort to IDLE next cycle, with no done pulse.
  - LS_WR runs to completion, because a store has already committed; its finished pulse still fires.
  - A pending pulse for the cycle of clear is suppressed, except a store's.
- rdy_in=0: all registers hold, mem_wr=0. A read byte arriving in the paused cycle is re-requested on resume (k not advanced).
- Reset mid-access: immediate return to IDLE, no pulse.

Test Plan:
- LW at 0x100, RAM bytes 11 22 33 44, lsb_pos=5 → mem_a 0x100..0x103 in T+1..T+4; lsb_finished in T+6 with val 0x44332211, pos 5.
- SH addr 0x200, val 0xABCD1234 → mem_wr=1 cycles T+1,T+2 with (0x200,0x34),(0x201,0x12); finished T+3; lsb_busy low in T+3.
- if_req and lsb_req together from reset (last_grant=IF) → LSB served first. Next IDLE cycle: lsb_busy=1 while if_req, so IF is granted; round-robin alternates over 3 back-to-back pairs.
- SB to 0x30000 with io_buffer_full=1 for 3 cycles → no mem_wr during stall; write occurs the cycle after release; finished one cycle later.
- clear asserted mid IF read (k=2) → no if_done, IDLE next cycle. Same for a store at k=1 → write bytes 2,3 still issued, finished pulses.
- rst_in low at k=1 of LW → outputs 0 immediately. After release, a new LB at 0x10 (byte 0x80) → val 0x00000080 in T+3.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - fetch / load-store / RAM bus bundle for mem_arbiter
interface mem_arbiter_if #(
    parameter int POS_W = 4
);
    logic             rdy_in;
    logic             clear;
    logic             io_buffer_full;
    logic             if_req;
    logic [31:0]      if_addr;
    logic             if_done;
    logic [31:0]      if_inst;
    logic             lsb_req;
    logic [POS_W-1:0] lsb_pos;
    logic             lsb_ls;
    logic [1:0]       lsb_len;
    logic [31:0]      lsb_addr;
    logic [31:0]      lsb_val;
    logic             lsb_busy;
    logic             lsb_finished;
    logic [31:0]      lsb_val_out;
    logic [POS_W-1:0] lsb_pos_out;
    logic [7:0]       mem_din;
    logic [7:0]       mem_dout;
    logic [31:0]      mem_a;
    logic             mem_wr;

    modport slave (
        input  rdy_in, clear, io_buffer_full,
        input  if_req, if_addr,
        output if_done, if_inst,
        input  lsb_req, lsb_pos, lsb_ls, lsb_len, lsb_addr, lsb_val,
        output lsb_busy, lsb_finished, lsb_val_out, lsb_pos_out,
        input  mem_din,
        output mem_dout, mem_a, mem_wr
    );

    modport master (
        output rdy_in, clear, io_buffer_full,
        output if_req, if_addr,
        input  if_done, if_inst,
        output lsb_req, lsb_pos, lsb_ls, lsb_len, lsb_addr, lsb_val,
        input  lsb_busy, lsb_finished, lsb_val_out, lsb_pos_out,
        output mem_din,
        input  mem_dout, mem_a, mem_wr
    );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin byte-serial RAM arbiter for fetch and load/store buffer
module mem_arbiter #(
    parameter int POS_W = 4
) (
    input  logic         clk_in,
    input  logic         rst_in,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, IF_RD, LS_RD, LS_WR} state_t;

    state_t           state, state_nx;
    logic             last_lsb, last_lsb_nx;
    logic [31:0]      base, base_nx;
    logic [31:0]      wdata, wdata_nx;
    logic [31:0]      rdata, rdata_nx;
    logic [1:0]       k, k_nx;
    logic [1:0]       last_k, last_k_nx;
    logic             got, got_nx;
    logic [POS_W-1:0] pos, pos_nx;
    logic             if_done_q, if_done_nx;
    logic             fin_q, fin_nx;
    logic             fin_st_q, fin_st_nx;

    logic [31:0] cur_a;
    logic [7:0]  wbyte;
    logic        busy, lsb_go, if_go, io_stall;

    assign cur_a    = base + {30'd0, k};
    assign busy     = (state != IDLE) | (last_lsb & bus.if_req);
    assign lsb_go   = bus.lsb_req & ~busy;
    // Fetch keeps if_req high through its done cycle; do not fetch the same word twice.
    assign if_go    = bus.if_req & ~if_done_q;
    assign io_stall = (cur_a[17:16] == 2'b11) & bus.io_buffer_full;

    always_comb begin
        wbyte = wdata[7:0];
        case (k)
            2'd0: wbyte = wdata[7:0];
            2'd1: wbyte = wdata[15:8];
            2'd2: wbyte = wdata[23:16];
            2'd3: wbyte = wdata[31:24];
            default: wbyte = wdata[7:0];
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state     <= IDLE;
            last_lsb  <= 1'b0;
            base      <= 32'd0;
            wdata     <= 32'd0;
            rdata     <= 32'd0;
            k         <= 2'd0;
            last_k    <= 2'd0;
            got       <= 1'b0;
            pos       <= '0;
            if_done_q <= 1'b0;
            fin_q     <= 1'b0;
            fin_st_q  <= 1'b0;
        end else begin
            state     <= state_nx;
            last_lsb  <= last_lsb_nx;
            base      <= base_nx;
            wdata     <= wdata_nx;
            rdata     <= rdata_nx;
            k         <= k_nx;
            last_k    <= last_k_nx;
            got       <= got_nx;
            pos       <= pos_nx;
            if_done_q <= if_done_nx;
            fin_q     <= fin_nx;
            fin_st_q  <= fin_st_nx;
        end
    end

    // got means mem_din this cycle carries byte k; the address on the bus is then k+1.
    always_comb begin
        state_nx    = state;
        last_lsb_nx = last_lsb;
        base_nx     = base;
        wdata_nx    = wdata;
        rdata_nx    = rdata;
        k_nx        = k;
        last_k_nx   = last_k;
        got_nx      = got;
        pos_nx      = pos;
        if_done_nx  = 1'b0;
        fin_nx      = 1'b0;
        fin_st_nx   = 1'b0;
        if (!bus.rdy_in) begin
            // The byte landing in a paused cycle is dropped and re-requested on resume.
            got_nx     = 1'b0;
            if_done_nx = if_done_q;
            fin_nx     = fin_q;
            fin_st_nx  = fin_st_q;
        end else begin
            case (state)
                IDLE: begin
                    if (lsb_go) begin
                        state_nx    = bus.lsb_ls ? LS_WR : LS_RD;
                        last_lsb_nx = 1'b1;
                        base_nx     = bus.lsb_addr;
                        wdata_nx    = bus.lsb_val;
                        pos_nx      = bus.lsb_pos;
                        rdata_nx    = 32'd0;
                        k_nx        = 2'd0;
                        got_nx      = 1'b0;
                        case (bus.lsb_len)
                            2'b00:   last_k_nx = 2'd0;
                            2'b01:   last_k_nx = 2'd1;
                            default: last_k_nx = 2'd3;
                        endcase
                    end else if (if_go) begin
                        state_nx    = IF_RD;
                        last_lsb_nx = 1'b0;
                        base_nx     = bus.if_addr;
                        rdata_nx    = 32'd0;
                        k_nx        = 2'd0;
                        got_nx      = 1'b0;
                        last_k_nx   = 2'd3;
                    end
                end
                IF_RD, LS_RD: begin
                    if (bus.clear) begin
                        state_nx = IDLE;
                        got_nx   = 1'b0;
                    end else if (got) begin
                        rdata_nx[{k, 3'b000} +: 8] = bus.mem_din;
                        if (k == last_k) begin
                            state_nx = IDLE;
                            got_nx   = 1'b0;
                            if (state == IF_RD) if_done_nx = 1'b1;
                            else                fin_nx     = 1'b1;
                        end else begin
                            k_nx = k + 2'd1;
                        end
                    end else begin
                        got_nx = 1'b1;
                    end
                end
                LS_WR: begin
                    // Stores are already committed, so clear does not stop them.
                    if (!io_stall) begin
                        if (k == last_k) begin
                            state_nx  = IDLE;
                            fin_nx    = 1'b1;
                            fin_st_nx = 1'b1;
                        end else begin
                            k_nx = k + 2'd1;
                        end
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    assign bus.lsb_busy     = busy;
    assign bus.mem_a        = (state == IDLE) ? 32'd0 : (got ? cur_a + 32'd1 : cur_a);
    assign bus.mem_wr       = bus.rdy_in & (state == LS_WR) & ~io_stall;
    assign bus.mem_dout     = (state == LS_WR) ? wbyte : 8'd0;
    assign bus.if_done      = if_done_q & bus.rdy_in & ~bus.clear;
    assign bus.lsb_finished = fin_q & bus.rdy_in & (fin_st_q | ~bus.clear);
    assign bus.if_inst      = rdata;
    assign bus.lsb_val_out  = rdata;
    assign bus.lsb_pos_out  = pos;
endmodule
